// File: rtl/register_slice_pkg.sv
// Shared definitions for the two-entry stream register slice.
package register_slice_pkg;

    // Width of the occupancy count (0..2 held beats).
    localparam int unsigned SZ_OCC = 2;

    // The encoding doubles as the occupancy value.
    typedef enum logic [SZ_OCC-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slice_state_t;

endpackage

// File: rtl/register.sv
// Enable register with an asynchronous reset.
// RST_POS_EDGE selects an active-high reset (1) or an active-low reset (0).
module register #(
    parameter int unsigned          SZ_DATA      = 32,
    parameter bit                   RST_POS_EDGE = 1'b0,
    parameter logic [SZ_DATA-1:0]   RST_STATE    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [SZ_DATA-1:0] d,
    output logic [SZ_DATA-1:0] q
);

    if (RST_POS_EDGE) begin : g_rst_high
        // Load d when enabled; clear on an active-high reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= RST_STATE;
            end else if (en) begin
                q <= d;
            end
        end
    end else begin : g_rst_low
        // Load d when enabled; clear on an active-low reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q <= RST_STATE;
            end else if (en) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/register_slice.sv
// Two-entry valid/ready skid buffer. It registers m_valid, m_data and s_ready, so neither
// the forward nor the backward path passes combinationally through the slice.
module register_slice
    import register_slice_pkg::*;
#(
    parameter int unsigned        SZ_DATA   = 32,
    parameter logic [SZ_DATA-1:0] RST_STATE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SZ_DATA-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [SZ_DATA-1:0] m_data,
    output logic [SZ_OCC-1:0]  occupancy
);

    slice_state_t       state_q;
    slice_state_t       state_d;
    logic               s_ready_q;
    logic               beat_in;
    logic               beat_out;
    logic               load_main;
    logic               load_skid;
    logic [SZ_DATA-1:0] main_d;
    logic [SZ_DATA-1:0] main_q;
    logic [SZ_DATA-1:0] skid_q;

    assign beat_in  = s_valid & s_ready_q;
    assign beat_out = m_valid & m_ready;

    // State register. s_ready_q resets low and only rises at the first edge after release,
    // which also acts as the post-reset enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != TWO);
        end
    end

    // Next state; flush overrides any accept or deliver on the same edge.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY:   if (beat_in) state_d = ONE;
                ONE: begin
                    if (beat_in && !beat_out) begin
                        state_d = TWO;
                    end else if (!beat_in && beat_out) begin
                        state_d = EMPTY;
                    end
                end
                TWO:     if (beat_out) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Outputs and data-store load strobes.
    always_comb begin
        m_valid   = (state_q != EMPTY);
        occupancy = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        main_d    = s_data;
        if (!flush) begin
            unique case (state_q)
                EMPTY:   load_main = beat_in;
                ONE: begin
                    load_main = beat_in & beat_out;
                    load_skid = beat_in & ~beat_out;
                end
                TWO: begin
                    load_main = beat_out;
                    main_d    = skid_q;
                end
                default: load_main = 1'b0;
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign m_data  = main_q;

    register #(
        .SZ_DATA      (SZ_DATA),
        .RST_POS_EDGE (1'b0),
        .RST_STATE    (RST_STATE)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (load_main),
        .d   (main_d),
        .q   (main_q)
    );

    register #(
        .SZ_DATA      (SZ_DATA),
        .RST_POS_EDGE (1'b0),
        .RST_STATE    (RST_STATE)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (load_skid),
        .d   (s_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_register_slice.sv
// Directed bench for register_slice: inputs change and outputs are sampled on the falling edge.
module tb_register_slice;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    register_slice #(
        .SZ_DATA   (32),
        .RST_STATE (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data  = 32'hDEAD_BEEF;

        // Reset held with traffic offered.
        tick();
        tick();
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_occ", {30'b0, occupancy}, 32'd0);
        s_valid = 1'b0;
        rst     = 1'b1;
        check("rel_s_ready_low", {31'b0, s_ready}, 32'd0);
        tick();
        check("rel_s_ready_high", {31'b0, s_ready}, 32'd1);
        check("rel_m_valid", {31'b0, m_valid}, 32'd0);

        // Single beat.
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        tick();
        s_valid = 1'b0;
        s_data  = 32'hFFFF_FFFF;
        check("single_m_valid", {31'b0, m_valid}, 32'd1);
        check("single_m_data", m_data, 32'hA5A5_0001);
        check("single_occ", {30'b0, occupancy}, 32'd1);
        tick();
        check("single_drain", {31'b0, m_valid}, 32'd0);
        check("single_occ0", {30'b0, occupancy}, 32'd0);

        // Streaming 16 beats at full rate.
        for (int i = 0; i < 16; i++) begin
            check("stream_s_ready", {31'b0, s_ready}, 32'd1);
            s_valid = 1'b1;
            s_data  = i;
            tick();
            check("stream_m_valid", {31'b0, m_valid}, 32'd1);
            check("stream_m_data", m_data, i);
            check("stream_occ", {30'b0, occupancy}, 32'd1);
        end
        s_valid = 1'b0;
        tick();
        check("stream_drain", {31'b0, m_valid}, 32'd0);

        // Backpressure.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h11;
        tick();
        check("bp_m_data_11", m_data, 32'h11);
        check("bp_s_ready_1", {31'b0, s_ready}, 32'd1);
        s_data = 32'h22;
        tick();
        check("bp_occ2", {30'b0, occupancy}, 32'd2);
        check("bp_s_ready_0", {31'b0, s_ready}, 32'd0);
        check("bp_m_data_hold", m_data, 32'h11);
        s_data = 32'h33;
        tick();
        check("bp_occ2_hold", {30'b0, occupancy}, 32'd2);
        check("bp_m_data_stable", m_data, 32'h11);
        check("bp_m_valid_stable", {31'b0, m_valid}, 32'd1);
        m_ready = 1'b1;
        check("bp_out_11", m_data, 32'h11);
        tick();
        check("bp_out_22_valid", {31'b0, m_valid}, 32'd1);
        check("bp_out_22", m_data, 32'h22);
        check("bp_occ_after_pop", {30'b0, occupancy}, 32'd1);
        check("bp_s_ready_back", {31'b0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
        check("bp_out_33_valid", {31'b0, m_valid}, 32'd1);
        check("bp_out_33", m_data, 32'h33);
        tick();
        check("bp_drain", {31'b0, m_valid}, 32'd0);

        // Flush with two held beats.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h66;
        tick();
        s_data = 32'h77;
        tick();
        check("fl_occ2", {30'b0, occupancy}, 32'd2);
        flush  = 1'b1;
        s_data = 32'h44;
        tick();
        flush = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("fl_occ0", {30'b0, occupancy}, 32'd0);
        check("fl_m_valid", {31'b0, m_valid}, 32'd0);
        check("fl_s_ready", {31'b0, s_ready}, 32'd1);
        tick();
        check("fl_no_44", {31'b0, m_valid}, 32'd0);

        // Asynchronous reset with two held beats.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h12;
        tick();
        s_data = 32'h34;
        tick();
        check("mr_occ2", {30'b0, occupancy}, 32'd2);
        s_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mr_m_valid", {31'b0, m_valid}, 32'd0);
        check("mr_s_ready", {31'b0, s_ready}, 32'd0);
        check("mr_occ", {30'b0, occupancy}, 32'd0);
        check("mr_m_data", m_data, 32'h0);
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b1;
        check("mr_rel_s_ready", {31'b0, s_ready}, 32'd0);
        tick();
        check("mr_s_ready_up", {31'b0, s_ready}, 32'd1);
        check("mr_no_stale", {31'b0, m_valid}, 32'd0);
        s_valid = 1'b1;
        s_data  = 32'h55;
        tick();
        s_valid = 1'b0;
        check("mr_55_valid", {31'b0, m_valid}, 32'd1);
        check("mr_55_data", m_data, 32'h55);
        tick();
        check("mr_drain", {31'b0, m_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
